// File: rtl/uart_apb_pkg.sv
// Shared constants for the APB UART: register offsets, bit positions, FSM encodings.
package uart_apb_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int STAT_TX_EMPTY  = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_RX_EMPTY  = 2;
    localparam int STAT_RX_FULL   = 3;
    localparam int STAT_TX_BUSY   = 4;
    localparam int STAT_PAR_ERR   = 5;
    localparam int STAT_FRAME_ERR = 6;
    localparam int STAT_OVERRUN   = 7;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_PAR_EN   = 2;
    localparam int CTRL_PAR_ODD  = 3;
    localparam int CTRL_IE_RX    = 4;
    localparam int CTRL_IE_TX    = 5;
    localparam int CTRL_IE_ERR   = 6;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_WAIT   = 3'd5;

    localparam logic [15:0] MIN_DIV = 16'd4;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head output; overflow/underflow requests are ignored.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO can proceed.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_apb_fifo.sv
// APB-slave UART with TX/RX FIFOs, programmable baud divisor, optional parity and level irq.
module uart_apb_fifo
    import uart_apb_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] padd,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslevrr,
    input  logic        ser_in,
    output logic        ser_out,
    output logic        irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic                 access, wr, rd;
    logic [1:0]           reg_sel;
    logic [6:0]           ctrl_q;
    logic [15:0]          baud_q, baud_new;
    logic                 par_err_q, frame_err_q, overrun_q;
    logic [2:0]           w1c;
    logic [7:0]           status;

    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_dout;
    logic [CW-1:0]        tx_count;
    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_BITS-1:0] rx_dout;
    logic [CW-1:0]        rx_count;

    logic [2:0]           tx_state;
    logic [15:0]          tx_cnt, tx_div;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par, tx_par_en, tx_bit_end, tx_go, tx_busy;

    logic                 rx_s1, rx_s2, rx_d;
    logic [2:0]           rx_state;
    logic [15:0]          rx_cnt, rx_div, rx_target;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_par_en, rx_par_odd, rx_active, rx_tick;
    logic                 perr_set, ferr_set, ovr_set, stop_ok;
    logic                 unused_bits;

    assign access  = psel & penable;
    assign wr      = access & pwrite;
    assign rd      = access & ~pwrite;
    assign reg_sel = padd[3:2];
    assign pready  = access;

    assign tx_push = wr & (reg_sel == REG_DATA) & pstrb[0] & ~tx_full;
    assign rx_pop  = rd & (reg_sel == REG_DATA) & ~rx_empty;
    assign tx_busy = (tx_state != TX_IDLE);
    assign status  = {overrun_q, frame_err_q, par_err_q, tx_busy,
                      rx_full, rx_empty, tx_full, tx_empty};

    assign unused_bits = ^{padd[31:4], padd[1:0], pwdata[31:16], pstrb[3:2], tx_count, rx_count};

    always_comb begin
        prdata  = '0;
        pslevrr = 1'b0;
        if (rd) begin
            case (reg_sel)
                REG_DATA: begin
                    if (rx_empty) pslevrr = 1'b1;
                    else          prdata[DATA_BITS-1:0] = rx_dout;
                end
                REG_STATUS: prdata[7:0]  = status;
                REG_CTRL:   prdata[6:0]  = ctrl_q;
                default:    prdata[15:0] = baud_q;
            endcase
        end else if (wr && reg_sel == REG_DATA && pstrb[0] && tx_full) begin
            pslevrr = 1'b1;
        end
    end

    assign baud_new = {pstrb[1] ? pwdata[15:8] : baud_q[15:8],
                       pstrb[0] ? pwdata[7:0]  : baud_q[7:0]};
    assign w1c = (wr && reg_sel == REG_STATUS && pstrb[0]) ? pwdata[7:5] : 3'b000;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            ctrl_q      <= '0;
            baud_q      <= 16'(CLKS_PER_BIT);
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (wr && reg_sel == REG_CTRL && pstrb[0]) begin
                ctrl_q <= pwdata[6:0];
            end
            if (wr && reg_sel == REG_BAUD && (|pstrb[1:0])) begin
                baud_q <= clamp_div(baud_new);
            end
            // A new error event in the clearing cycle wins over the clear.
            par_err_q   <= (par_err_q   & ~w1c[0]) | perr_set;
            frame_err_q <= (frame_err_q & ~w1c[1]) | ferr_set;
            overrun_q   <= (overrun_q   & ~w1c[2]) | ovr_set;
        end
    end

    assign irq = (ctrl_q[CTRL_IE_RX] & ~rx_empty) | (ctrl_q[CTRL_IE_TX] & tx_empty)
               | (ctrl_q[CTRL_IE_ERR] & (par_err_q | frame_err_q | overrun_q));

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(pclk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(pwdata[DATA_BITS-1:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(pclk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_sh),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // TX: a new frame may start from IDLE or straight out of the last stop-bit clock.
    assign tx_bit_end = tx_busy & (tx_cnt == tx_div - 16'd1);
    assign tx_go      = ctrl_q[CTRL_TX_EN] & ~tx_empty
                      & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_bit_end));
    assign tx_pop     = tx_go;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_div    <= 16'(CLKS_PER_BIT);
            tx_bit    <= '0;
            tx_sh     <= '0;
            tx_par    <= 1'b0;
            tx_par_en <= 1'b0;
        end else if (tx_go) begin
            tx_state  <= TX_START;
            tx_cnt    <= '0;
            tx_div    <= baud_q;
            tx_sh     <= tx_dout;
            tx_par    <= (^tx_dout) ^ ctrl_q[CTRL_PAR_ODD];
            tx_par_en <= ctrl_q[CTRL_PAR_EN];
        end else if (tx_busy) begin
            if (!tx_bit_end) begin
                tx_cnt <= tx_cnt + 16'd1;
            end else begin
                tx_cnt <= '0;
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                    end
                    TX_DATA: begin
                        tx_sh <= tx_sh >> 1;
                        if (tx_bit == 4'(DATA_BITS - 1)) tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                        else                             tx_bit   <= tx_bit + 4'd1;
                    end
                    TX_PARITY: tx_state <= TX_STOP;
                    default:   tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (tx_state)
            TX_START:  ser_out = 1'b0;
            TX_DATA:   ser_out = tx_sh[0];
            TX_PARITY: ser_out = tx_par;
            default:   ser_out = 1'b1;
        endcase
    end

    // RX: first sample at half a bit after the detected edge, then one per divisor.
    assign rx_active = (rx_state == RX_START) | (rx_state == RX_DATA)
                     | (rx_state == RX_PARITY) | (rx_state == RX_STOP);
    assign rx_target = (rx_state == RX_START) ? (rx_div >> 1) - 16'd1 : rx_div - 16'd1;
    assign rx_tick   = rx_active & (rx_cnt == rx_target);
    assign perr_set  = rx_tick & (rx_state == RX_PARITY) & (rx_s2 != ((^rx_sh) ^ rx_par_odd));
    assign stop_ok   = rx_tick & (rx_state == RX_STOP) & rx_s2;
    assign ferr_set  = rx_tick & (rx_state == RX_STOP) & ~rx_s2;
    assign rx_push   = stop_ok & ~rx_full;
    assign ovr_set   = stop_ok & rx_full;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_div     <= 16'(CLKS_PER_BIT);
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
        end else begin
            rx_s1 <= ser_in;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            case (rx_state)
                RX_IDLE: begin
                    if (ctrl_q[CTRL_RX_EN] && rx_d && !rx_s2) begin
                        rx_state   <= RX_START;
                        rx_cnt     <= '0;
                        rx_div     <= baud_q;
                        rx_par_en  <= ctrl_q[CTRL_PAR_EN];
                        rx_par_odd <= ctrl_q[CTRL_PAR_ODD];
                    end
                end
                RX_WAIT: begin
                    if (rx_s2) rx_state <= RX_IDLE;
                end
                default: begin
                    if (!rx_tick) begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end else begin
                        rx_cnt <= '0;
                        case (rx_state)
                            RX_START: begin
                                rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                                rx_bit   <= '0;
                            end
                            RX_DATA: begin
                                rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                                if (rx_bit == 4'(DATA_BITS - 1)) begin
                                    rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                                end else begin
                                    rx_bit <= rx_bit + 4'd1;
                                end
                            end
                            RX_PARITY: rx_state <= RX_STOP;
                            default:   rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_fifo.sv
// Directed bench for uart_apb_fifo: registers, TX waveform, loopback FIFO fill, parity/frame errors.
module tb_uart_apb_fifo;

    logic        pclk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] padd, pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslevrr, ser_in, ser_out, irq;
    logic        ser_drv, loop;

    int n_cmp = 0;
    int n_err = 0;
    logic last_rdy;

    assign ser_in = loop ? ser_out : ser_drv;

    uart_apb_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .CLKS_PER_BIT(87)) dut (
        .pclk(pclk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .padd(padd), .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
        .pslevrr(pslevrr), .ser_in(ser_in), .ser_out(ser_out), .irq(irq)
    );

    always #5 pclk = ~pclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic w, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; padd = {28'd0, addr}; pwdata = wdata;
        pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        rdata = prdata; err = pslevrr; last_rdy = pready;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        logic e;
        apb_xfer(1'b1, addr, wdata, d, e);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp,
                          input logic exp_err);
        logic [31:0] d;
        logic e;
        apb_xfer(1'b0, addr, 32'd0, d, e);
        check(tag, d, exp);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic bit_time();
        repeat (8) @(posedge pclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic with_par, input logic par_bit,
                              input logic stop_bit);
        ser_drv = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            ser_drv = data[i];
            bit_time();
        end
        if (with_par) begin
            ser_drv = par_bit;
            bit_time();
        end
        ser_drv = stop_bit;
        bit_time();
        ser_drv = 1'b1;
        repeat (16) @(posedge pclk);
        #1;
    endtask

    task automatic wait_fall(output logic ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 40) begin
            @(negedge pclk);
            if (ser_out == 1'b0) ok = 1'b1;
            n++;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e, ok;
        logic [9:0]  frame;
        int          good, errs;

        rst = 1'b1; psel = 0; penable = 0; pwrite = 0; padd = 0; pwdata = 0; pstrb = 0;
        ser_drv = 1'b1; loop = 1'b0; last_rdy = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_ser_out", {31'd0, ser_out}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        rst = 1'b0;

        rd_chk("rst_status", 4'h4, 32'h05, 1'b0);
        check("pready_access", {31'd0, last_rdy}, 32'd1);
        rd_chk("rst_baud", 4'hC, 32'd87, 1'b0);
        rd_chk("rst_ctrl", 4'h8, 32'd0, 1'b0);

        wr_reg(4'hC, 32'd2);
        rd_chk("baud_min", 4'hC, 32'd4, 1'b0);
        wr_reg(4'hC, 32'd8);
        rd_chk("baud_8", 4'hC, 32'd8, 1'b0);

        // TX waveform for 0xA5: start, LSB-first data, stop
        wr_reg(4'h8, 32'h03);
        wr_reg(4'h0, 32'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        fork
            begin
                wait_fall(ok);
                check("tx_start_seen", {31'd0, ok}, 32'd1);
                for (int b = 0; b < 10; b++) begin
                    good = 0;
                    for (int k = 0; k < 8; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge pclk);
                        if (ser_out == frame[b]) good++;
                    end
                    check($sformatf("tx_bit%0d", b), good, 8);
                end
            end
            begin
                logic [31:0] sd;
                logic se;
                repeat (30) @(posedge pclk);
                apb_xfer(1'b0, 4'h4, 32'd0, sd, se);
                check("tx_busy_mid", {31'd0, sd[4]}, 32'd1);
            end
        join
        rd_chk("tx_done_status", 4'h4, 32'h05, 1'b0);

        // Loopback: fill TX FIFO with TX disabled, then release
        loop = 1'b1;
        wr_reg(4'h8, 32'h02);
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            apb_xfer(1'b1, 4'h0, i, d, e);
            if (e) errs++;
        end
        check("fill_errs", errs, 0);
        apb_xfer(1'b1, 4'h0, 32'h10, d, e);
        check("tx_full_err", {31'd0, e}, 32'd1);
        rd_chk("tx_full_status", 4'h4, 32'h06, 1'b0);
        wr_reg(4'h8, 32'h03);
        repeat (16 * 80 + 100) @(posedge pclk);
        rd_chk("rx_full_status", 4'h4, 32'h09, 1'b0);
        for (int i = 0; i < 16; i++) begin
            rd_chk($sformatf("rx_byte%0d", i), 4'h0, i, 1'b0);
        end
        rd_chk("loop_end_status", 4'h4, 32'h05, 1'b0);
        loop = 1'b0;

        // Odd parity: 0x07 has three ones, so the parity bit is 0
        wr_reg(4'h8, 32'h0F);
        wr_reg(4'h0, 32'h07);
        wait_fall(ok);
        repeat (76) @(negedge pclk);
        check("tx_parity_bit", {31'd0, ser_out}, 32'd0);
        repeat (8) @(negedge pclk);
        check("tx_stop_bit", {31'd0, ser_out}, 32'd1);
        repeat (20) @(posedge pclk);
        #1;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        rd_chk("par_err_status", 4'h4, 32'h21, 1'b0);
        rd_chk("par_byte", 4'h0, 32'h07, 1'b0);
        wr_reg(4'h4, 32'h20);
        rd_chk("par_clr_status", 4'h4, 32'h05, 1'b0);

        // Framing error, empty read, error interrupt, glitch rejection
        wr_reg(4'h8, 32'h03);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        rd_chk("frame_err_status", 4'h4, 32'h45, 1'b0);
        wr_reg(4'h8, 32'h43);
        @(negedge pclk);
        check("irq_err", {31'd0, irq}, 32'd1);
        rd_chk("empty_read", 4'h0, 32'h0, 1'b1);
        wr_reg(4'h4, 32'h40);
        @(negedge pclk);
        check("irq_err_clr", {31'd0, irq}, 32'd0);
        rd_chk("frame_clr_status", 4'h4, 32'h05, 1'b0);
        @(posedge pclk); #1;
        ser_drv = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        ser_drv = 1'b1;
        repeat (40) @(posedge pclk);
        rd_chk("glitch_status", 4'h4, 32'h05, 1'b0);
        wr_reg(4'h8, 32'h20);
        @(negedge pclk);
        check("irq_tx_empty", {31'd0, irq}, 32'd1);
        wr_reg(4'h8, 32'h10);
        @(negedge pclk);
        check("irq_rx_empty", {31'd0, irq}, 32'd0);

        // Reset in the middle of a frame with bytes still queued
        wr_reg(4'h8, 32'h01);
        for (int i = 0; i < 4; i++) wr_reg(4'h0, 32'h00);
        repeat (20) @(negedge pclk);
        check("tx_mid_low", {31'd0, ser_out}, 32'd0);
        @(posedge pclk); #1;
        rst = 1'b1;
        #1;
        check("rst_async_ser_out", {31'd0, ser_out}, 32'd1);
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        rd_chk("post_rst_status", 4'h4, 32'h05, 1'b0);
        rd_chk("post_rst_ctrl", 4'h8, 32'h00, 1'b0);
        repeat (20) @(negedge pclk);
        check("post_rst_idle", {31'd0, ser_out}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_apb_fifo.md
Name: uart_apb_fifo

Overview:
APB-slave UART with parametrised data width, TX/RX FIFOs of parametrised depth and a run-time programmable baud divisor. Optional parity, sticky error flags and a level interrupt.
Generalises the existing single-byte uart_apb peripheral, which has no buffering and a fixed baud rate.
Sits on the peripheral APB bus beside the GPIO block; ser_out/ser_in go to pads or to a peer UART.

Parameters:
DATA_BITS, 8, character width, 5..9
FIFO_DEPTH, 16, entries per FIFO, power of 2, >=2
CLKS_PER_BIT, 87, reset value of BAUD register (10 MHz pclk / 115200)

Ports:
pclk  in  1  clock
rst  in  1  asynchronous reset, active-high
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1=write, 0=read
padd  in  32  byte address; bits [3:2] decoded, others ignored
pwdata  in  32  write data
pstrb  in  4  byte-lane strobes
pready  out  1  transfer ready
prdata  out  32  read data
pslevrr  out  1  APB slave error
ser_in  in  1  serial receive line, asynchronous
ser_out  out  1  serial transmit line, idle high
irq  out  1  level interrupt

Behaviour:
- Reset values: pready=0, prdata=0, pslevrr=0, ser_out=1, irq=0, FIFOs empty, flags clear, CTRL=0, BAUD=CLKS_PER_BIT. Reset mid-frame aborts the frame immediately.
- APB: zero wait states. pready=1 only when psel&penable. Transfer takes effect in that cycle. prdata/pslevrr are valid in the same cycle and 0 otherwise.
- Register map:
  - 0x0 DATA: write pushes pwdata[DATA_BITS-1:0] to TX FIFO if pstrb[0]=1; read pops RX FIFO.
  - 0x4 STATUS: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_busy, [5] parity_err, [6] frame_err, [7] overrun. Bits 5..7 are sticky and W1C; other bits are read-only.
  - 0x8 CTRL: [0] tx_en, [1] rx_en, [2] parity_en, [3] parity_odd, [4] ie_rx_nonempty, [5] ie_tx_empty, [6] ie_err.
  - 0xC BAUD: [15:0] divisor; lanes honoured; writes below 4 store 4.
- pslevrr=1 for: write DATA with TX full (data dropped); read DATA with RX empty (prdata=0, no pop). Other transfers never error.
- irq = (ie_rx_nonempty & ~rx_empty) | (ie_tx_empty & tx_empty) | (ie_err & (parity_err|frame_err|overrun)).
- TX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE.
  - Leaves IDLE when tx_en & ~tx_empty; pops on the START entry cycle.
  - Each bit lasts exactly divisor clocks. Divisor is latched at START; BAUD writes affect the next frame only.
  - Data is sent LSB first. Parity = XOR of data, inverted if parity_odd.
  - Back-to-back frames have no idle gap. Clearing tx_en mid-frame finishes the current frame.
- RX FSM: 2-FF synchroniser, then IDLE->START->DATA->[PARITY]->STOP.
  - rx_en & falling edge enters START. Line is sampled at divisor/2 (truncated) and every divisor thereafter.
  - Start sample high -> glitch, return to IDLE with nothing pushed.
  - Parity mismatch sets parity_err; byte is still pushed.
  - Stop sample 0 sets frame_err; byte is discarded. RX then waits for line high before IDLE.
  - Push when RX full sets overrun; new byte is dropped and FIFO contents kept.
- FIFO: simultaneous push and pop in the same cycle leaves count unchanged; push when full / pop when empty are no-ops. Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package uart_apb_pkg: register offsets, STATUS/CTRL bit indices, TX/RX state encodings, minimum divisor constant (4).
- Sub-module uart_fifo (WIDTH, DEPTH; push, pop, din, dout, full, empty, count), instantiated for TX and RX.
- TX/RX FSMs, register file and APB decode stay in the top.

Test Plan:
- Reset then read STATUS -> prdata=0x05 (tx_empty, rx_empty), ser_out=1, irq=0.
- BAUD=8, CTRL=0x03, write DATA=0xA5 -> ser_out: 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each level held 8 pclk. Frame total 80 clocks; tx_busy high throughout.
- Loop ser_out->ser_in, write 16 bytes 0x00..0x0F back-to-back -> 17th write gives pslevrr=1. RX later yields 0x00..0x0F in order, with no overrun.
- Parity: CTRL=0x0F, send 0x07 -> parity bit 0. Inject flipped parity on ser_in -> parity_err=1, byte 0x07 still read back. Write STATUS=0x20 clears the flag.
- ser_in stop bit forced 0 -> frame_err=1, RX FIFO stays empty. Read DATA -> pslevrr=1, prdata=0. ser_in low pulse of 2 clocks at BAUD=8 -> no byte, no flags.
- Assert rst mid-TX-frame with 3 bytes queued -> ser_out=1 immediately; after release tx_empty=1 and the FSM is idle.
